// File: rtl/sumermcu_gpio_filter_pkg.sv
// Shared defaults and types for the sumermcu GPIO input filter.
package sumermcu_gpio_filter_pkg;

  localparam int GPIO_WIDTH       = 16;
  localparam int FILT_CNT_W       = 8;
  localparam int FILT_SYNC_STAGES = 2;

  typedef logic [FILT_CNT_W-1:0] filt_cnt_t;

  // Per-bit update selected each cycle by the filter decode.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_BYPASS,
    ACT_CLEAR,
    ACT_COUNT,
    ACT_FLIP
  } filt_act_e;

endpackage

// File: rtl/sumermcu_gpio_filter_bit.sv
// One pin: synchroniser chain, debounce counter, registered level and change pulse.
module sumermcu_gpio_filter_bit
  import sumermcu_gpio_filter_pkg::*;
#(
  parameter int CNT_W       = FILT_CNT_W,
  parameter int SYNC_STAGES = FILT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_raw,
  input  logic             i_strobe,
  input  logic [CNT_W-1:0] i_thresh,
  output logic             o_pin,
  output logic             o_changed
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pin;
  logic                   r_changed;

  logic                   w_sync;
  logic                   w_bypass;
  logic [CNT_W:0]         w_cnt_inc;
  logic                   w_reached;
  filt_act_e              w_act;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_bypass  = (i_thresh == '0);
  // One extra bit so cnt+1 never wraps, even when thresh was lowered below cnt.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_reached = (w_cnt_inc >= {1'b0, i_thresh});

  always_comb begin
    w_act = ACT_IDLE;
    if (w_bypass)              w_act = ACT_BYPASS;
    else if (i_strobe) begin
      if (w_sync == r_pin)     w_act = ACT_CLEAR;
      else if (w_reached)      w_act = ACT_FLIP;
      else                     w_act = ACT_COUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pin     <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      case (w_act)
        ACT_BYPASS: begin
          r_pin     <= w_sync;
          r_changed <= (w_sync != r_pin);
          r_cnt     <= '0;
        end
        ACT_CLEAR: begin
          r_cnt     <= '0;
          r_changed <= 1'b0;
        end
        ACT_COUNT: begin
          r_cnt     <= w_cnt_inc[CNT_W-1:0];
          r_changed <= 1'b0;
        end
        ACT_FLIP: begin
          r_pin     <= w_sync;
          r_cnt     <= '0;
          r_changed <= 1'b1;
        end
        default: r_changed <= 1'b0;
      endcase
    end
  end

  assign o_pin     = r_pin;
  assign o_changed = r_changed;

endmodule

// File: rtl/sumermcu_gpio_filter.sv
// GPIO input conditioning: per-pin sync + debounce, shared sample prescaler.
module sumermcu_gpio_filter
  import sumermcu_gpio_filter_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int CNT_W       = FILT_CNT_W,
  parameter int SYNC_STAGES = FILT_SYNC_STAGES,
  parameter int PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_raw,
  input  logic [CNT_W-1:0] thresh,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] changed
);

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] r_pcnt;
  logic              w_strobe;

  // With PRESCALE == 1 the counter sits at 0 == PCNT_LAST, so strobe is always high.
  assign w_strobe = (r_pcnt == PCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_strobe) r_pcnt <= '0;
    else                 r_pcnt <= r_pcnt + 1'b1;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sumermcu_gpio_filter_bit #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (pin_raw[gi]),
      .i_strobe  (w_strobe),
      .i_thresh  (thresh),
      .o_pin     (pin_o[gi]),
      .o_changed (changed[gi])
    );
  end

endmodule

// File: tb/tb_sumermcu_gpio_filter.sv
// Directed bench: per-cycle vector table on a PRESCALE=1 instance, plus prescale and threshold sequences.
module tb_sumermcu_gpio_filter;

  logic        clk;
  logic        rst1, rst4;
  logic [15:0] raw1, raw4;
  logic [7:0]  th1, th4;
  logic [15:0] pin1, pin4, chg1, chg4;

  int n_vec = 0;
  int n_bad = 0;

  sumermcu_gpio_filter #(.WIDTH(16), .CNT_W(8), .SYNC_STAGES(2), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst1), .pin_raw(raw1), .thresh(th1), .pin_o(pin1), .changed(chg1)
  );

  sumermcu_gpio_filter #(.WIDTH(16), .CNT_W(8), .SYNC_STAGES(2), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst4), .pin_raw(raw4), .thresh(th4), .pin_o(pin4), .changed(chg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] raw;
    logic [7:0]  th;
    logic [15:0] pin;
    logic [15:0] chg;
  } vec_t;

  vec_t vecs[160];
  int   nv = 0;

  function automatic void add(logic r, logic [15:0] raw, logic [7:0] th,
                              logic [15:0] pin, logic [15:0] chg);
    vecs[nv].rst = r;
    vecs[nv].raw = raw;
    vecs[nv].th  = th;
    vecs[nv].pin = pin;
    vecs[nv].chg = chg;
    nv++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          n;
    int          pc;
    logic        found, strb, flip_strb, stay_low;

    rst1 = 1'b1; raw1 = '0; th1 = 8'd3;
    rst4 = 1'b1; raw4 = '0; th4 = 8'd2;

    // Reset with all pads high, thresh 3: flip 4 edges after release.
    add(1, 16'hFFFF, 3, 16'h0000, 16'h0000);
    add(1, 16'hFFFF, 3, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) add(0, 16'hFFFF, 3, 16'h0000, 16'h0000);
    add(0, 16'hFFFF, 3, 16'hFFFF, 16'hFFFF);
    add(0, 16'hFFFF, 3, 16'hFFFF, 16'h0000);

    // Glitch of 3 cycles on pin 0 with thresh 4 is rejected.
    add(1, 16'h0000, 4, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) add(0, 16'h0001, 4, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) add(0, 16'h0000, 4, 16'h0000, 16'h0000);
    // 4-cycle pulse passes at k+5, then the fall is debounced the same way.
    for (int i = 0; i < 4; i++) add(0, 16'h0001, 4, 16'h0000, 16'h0000);
    add(0, 16'h0000, 4, 16'h0000, 16'h0000);
    add(0, 16'h0000, 4, 16'h0001, 16'h0001);
    for (int i = 0; i < 3; i++) add(0, 16'h0000, 4, 16'h0001, 16'h0000);
    add(0, 16'h0000, 4, 16'h0000, 16'h0001);
    add(0, 16'h0000, 4, 16'h0000, 16'h0000);

    // Bypass: pin 5 toggling every cycle, output follows 2 edges later.
    for (int t = 0; t < 8; t++)
      add(0, (t % 2 == 0) ? 16'h0020 : 16'h0000, 0,
          (t >= 2 && (t % 2 == 0)) ? 16'h0020 : 16'h0000,
          (t >= 2) ? 16'h0020 : 16'h0000);

    // Independent pins, thresh 5: pin 1 steps at m, pin 2 at m+2.
    add(1, 16'h0000, 5, 16'h0000, 16'h0000);
    add(0, 16'h0002, 5, 16'h0000, 16'h0000);
    add(0, 16'h0002, 5, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) add(0, 16'h0006, 5, 16'h0000, 16'h0000);
    add(0, 16'h0006, 5, 16'h0002, 16'h0002);
    add(0, 16'h0006, 5, 16'h0002, 16'h0000);
    add(0, 16'h0006, 5, 16'h0006, 16'h0004);
    add(0, 16'h0006, 5, 16'h0006, 16'h0000);

    // Same steps, reset mid-count: both pins restart a full count.
    add(1, 16'h0000, 5, 16'h0006, 16'h0000);
    add(0, 16'h0002, 5, 16'h0000, 16'h0000);
    add(0, 16'h0002, 5, 16'h0000, 16'h0000);
    add(0, 16'h0006, 5, 16'h0000, 16'h0000);
    add(0, 16'h0006, 5, 16'h0000, 16'h0000);
    add(1, 16'h0006, 5, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) add(0, 16'h0006, 5, 16'h0000, 16'h0000);
    add(0, 16'h0006, 5, 16'h0006, 16'h0006);
    add(0, 16'h0006, 5, 16'h0006, 16'h0000);

    // The reset vector of the mid-count block expects pin_o cleared, not held.
    vecs[nv - 14].pin = 16'h0000;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      rst1 = vecs[i].rst;
      raw1 = vecs[i].raw;
      th1  = vecs[i].th;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pin_o", i), {16'h0, pin1}, {16'h0, vecs[i].pin});
      check($sformatf("vec%0d changed", i), {16'h0, chg1}, {16'h0, vecs[i].chg});
    end

    // Threshold lowered mid-count on pin 3.
    @(negedge clk); rst1 = 1'b1; raw1 = '0; th1 = 8'd200;
    @(posedge clk);
    @(negedge clk); rst1 = 1'b0; raw1 = 16'h0008;
    stay_low = 1'b1;
    for (int i = 0; i < 52; i++) begin
      @(posedge clk); #1;
      if (pin1 != 16'h0000 || chg1 != 16'h0000) stay_low = 1'b0;
    end
    check("thr_hold_low", {31'h0, stay_low}, 32'd1);
    check("thr_cnt50", {24'h0, dut1.g_bit[3].u_bit.r_cnt}, 32'd50);
    @(negedge clk); th1 = 8'd10;
    @(posedge clk); #1;
    check("thr_flip pin_o", {16'h0, pin1}, 32'h0008);
    check("thr_flip changed", {16'h0, chg1}, 32'h0008);
    check("thr_cnt_clr", {24'h0, dut1.g_bit[3].u_bit.r_cnt}, 32'd0);
    @(posedge clk); #1;
    check("thr_after changed", {16'h0, chg1}, 32'h0000);
    check("thr_after pin_o", {16'h0, pin1}, 32'h0008);

    // Prescale 4, thresh 2: step pin 15 at each of the four strobe phases.
    for (int d = 0; d < 4; d++) begin
      @(negedge clk); rst4 = 1'b1; raw4 = '0; th4 = 8'd2;
      @(posedge clk); #1;
      check($sformatf("pre%0d reset pin_o", d), {16'h0, pin4}, 32'h0);
      pc = 0;
      for (int j = 0; j < d; j++) begin
        @(negedge clk); rst4 = 1'b0;
        @(posedge clk); pc = (pc + 1) % 4;
      end
      @(negedge clk); rst4 = 1'b0; raw4 = 16'h8000;
      n = 0; found = 1'b0; flip_strb = 1'b0;
      while (!found && n < 20) begin
        @(posedge clk);
        n++;
        strb = (pc == 3);
        pc = (pc + 1) % 4;
        #1;
        if (pin4[15]) begin
          found     = 1'b1;
          flip_strb = strb;
          check($sformatf("pre%0d changed", d), {16'h0, chg4}, 32'h8000);
        end
      end
      check($sformatf("pre%0d found", d), {31'h0, found}, 32'd1);
      check($sformatf("pre%0d in_window", d), {31'h0, (n >= 7 && n <= 10)}, 32'd1);
      check($sformatf("pre%0d strobe_aligned", d), {31'h0, flip_strb}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("pre%0d pulse_end", d), {16'h0, chg4}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
